// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Bundle of the fetch-stage control, instruction-memory and
//                IF/ID pipeline signals. The master modport is the fetch
//                controller; the slave modport is the surrounding pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_cond;
    logic [31:0] rs_d;
    logic [11:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        halted;
    logic        fetch_err;

    modport master (
        input  stall, npc_sel, br_cond, rs_d, im_instr,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, halted, fetch_err
    );

    modport slave (
        output stall, npc_sel, br_cond, rs_d, im_instr,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, halted, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller with IF/ID register, branch /
//                jump / jr redirect, syscall halt and illegal-PC fault.
//                Macro DELAY_SLOT_EN: when defined the instruction fetched in
//                a redirect cycle is kept as a valid delay slot; otherwise it
//                is squashed into a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_7000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_ctrl_if.master  bus
);

    localparam logic [1:0]  c_RUN     = 2'd0;
    localparam logic [1:0]  c_HALT    = 2'd1;
    localparam logic [1:0]  c_FAULT   = 2'd2;
    localparam logic [31:0] c_SYSCALL = 32'h0000_000C;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [13:0] w_off;
    logic        w_unused_off;
    logic        w_legal;
    logic        w_syscall;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_redirect;
    logic [31:0] w_target;

    // Only the low 14 bits of the PC offset reach the instruction memory.
    assign w_off        = pc_f_q[13:0] - PC_BASE[13:0];
    assign w_unused_off = ^w_off[1:0];

    assign w_legal   = (pc_f_q >= PC_BASE) && (pc_f_q < PC_LIMIT) && (pc_f_q[1:0] == 2'b00);
    assign w_syscall = ifid_valid_q && (ifid_instr_q == c_SYSCALL);

    // Targets come only from the instruction sitting in IF/ID.
    assign w_br_off = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
    assign w_br_tgt = ifid_pc_q + 32'd4 + w_br_off;
    assign w_j_tgt  = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};

    // Select the redirect target and decide whether a redirect happens.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_br_tgt;
        case (bus.npc_sel)
            2'b01: begin
                w_redirect = bus.br_cond;
                w_target   = w_br_tgt;
            end
            2'b10: begin
                w_redirect = 1'b1;
                w_target   = w_j_tgt;
            end
            2'b11: begin
                w_redirect = 1'b1;
                w_target   = bus.rs_d;
            end
            default: begin
                w_redirect = 1'b0;
                w_target   = w_br_tgt;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a syscall in D outranks a fault on the younger fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_RUN: begin
                if (!bus.stall) begin
                    if (w_syscall) begin
                        state_d = c_HALT;
                    end else if (!w_legal) begin
                        state_d = c_FAULT;
                    end
                end
            end
            c_HALT:  state_d = c_HALT;
            c_FAULT: state_d = c_FAULT;
            default: state_d = c_RUN;
        endcase
    end

    // Output logic: status flags and next values of the PC and IF/ID register.
    always_comb begin
        bus.halted    = (state_q == c_HALT);
        bus.fetch_err = (state_q == c_FAULT);
        pc_f_d        = pc_f_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_valid_d  = ifid_valid_q;
        case (state_q)
            c_RUN: begin
                if (!bus.stall) begin
                    if (w_syscall || !w_legal) begin
                        // Entering HALT or FAULT: squash IF/ID, freeze the PC.
                        ifid_instr_d = 32'd0;
                        ifid_pc_d    = pc_f_q;
                        ifid_valid_d = 1'b0;
                    end else if (w_redirect) begin
                        pc_f_d    = w_target;
                        ifid_pc_d = pc_f_q;
`ifdef DELAY_SLOT_EN
                        ifid_instr_d = bus.im_instr;
                        ifid_valid_d = 1'b1;
`else
                        ifid_instr_d = 32'd0;
                        ifid_valid_d = 1'b0;
`endif
                    end else begin
                        pc_f_d       = pc_f_q + 32'd4;
                        ifid_instr_d = bus.im_instr;
                        ifid_pc_d    = pc_f_q;
                        ifid_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                ifid_instr_d = 32'd0;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q       <= PC_BASE;
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= PC_BASE;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_f_q       <= pc_f_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign bus.im_addr = w_off[13:2];
    assign bus.pc_f    = pc_f_q;
    assign bus.instr_d = ifid_instr_q;
    assign bus.pc_d    = ifid_pc_q;
    assign bus.pc8_d   = ifid_pc_q + 32'd8;
    assign bus.valid_d = ifid_valid_q;

endmodule
`default_nettype wire
